// File: rtl/htif_pkg.sv
// rtl/htif_pkg.sv - HTIF host poller shared widths, CSR addresses and FSM state codes
package htif_pkg;

    localparam int HTIF_PCR_WIDTH = 64;
    localparam int CSR_ADDR_WIDTH = 12;

    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_ADDR_TO_HOST   = 12'h780;
    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_ADDR_FROM_HOST = 12'h781;

    typedef logic [2:0] state_t;

    localparam state_t ST_HOLD     = 3'd0;
    localparam state_t ST_WAIT     = 3'd1;
    localparam state_t ST_RD_REQ   = 3'd2;
    localparam state_t ST_RD_RESP  = 3'd3;
    localparam state_t ST_CLR_REQ  = 3'd4;
    localparam state_t ST_CLR_RESP = 3'd5;
    localparam state_t ST_PUSH     = 3'd6;
    localparam state_t ST_HALT     = 3'd7;

    // riscv-tests signal test completion by setting bit 0 of tohost.
    function automatic logic is_exit_msg(input logic [HTIF_PCR_WIDTH-1:0] value);
        return value[0];
    endfunction

endpackage

// File: rtl/htif_host_poller.sv
// rtl/htif_host_poller.sv - HTIF host initiator: holds core reset, polls and clears tohost, forwards messages
module htif_host_poller
    import htif_pkg::*;
#(
    parameter int unsigned                  RESET_HOLD    = 8,
    parameter int unsigned                  POLL_INTERVAL = 16,
    parameter logic [CSR_ADDR_WIDTH-1:0]    ADDR_TOHOST   = CSR_ADDR_TO_HOST
) (
    input  logic                            hclk,
    input  logic                            hresetn,
    output logic                            htif_reset,
    output logic                            htif_pcr_req_valid,
    input  logic                            htif_pcr_req_ready,
    output logic                            htif_pcr_req_rw,
    output logic [CSR_ADDR_WIDTH-1:0]       htif_pcr_req_addr,
    output logic [HTIF_PCR_WIDTH-1:0]       htif_pcr_req_data,
    input  logic                            htif_pcr_resp_valid,
    output logic                            htif_pcr_resp_ready,
    input  logic [HTIF_PCR_WIDTH-1:0]       htif_pcr_resp_data,
    output logic                            msg_valid,
    input  logic                            msg_ready,
    output logic [HTIF_PCR_WIDTH-1:0]       msg_data,
    output logic                            done,
    output logic                            pass,
    output logic [HTIF_PCR_WIDTH-2:0]       exit_code
);

    localparam int unsigned CNT_MAX = (RESET_HOLD > POLL_INTERVAL) ? RESET_HOLD : POLL_INTERVAL;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD - 1);
    localparam logic [CNT_W-1:0] POLL_LOAD = CNT_W'(POLL_INTERVAL - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       htif_reset_q, htif_reset_d;
    logic [HTIF_PCR_WIDTH-1:0]  msg_data_q, msg_data_d;
    logic                       done_q, done_d;
    logic                       pass_q, pass_d;
    logic [HTIF_PCR_WIDTH-2:0]  exit_code_q, exit_code_d;

    logic req_fire;
    logic resp_fire;
    logic msg_fire;

    // Handshake outputs decode straight from the state so they are stable for the whole state.
    assign htif_pcr_req_valid  = (state_q == ST_RD_REQ) || (state_q == ST_CLR_REQ);
    assign htif_pcr_req_rw     = (state_q == ST_CLR_REQ);
    assign htif_pcr_req_addr   = ADDR_TOHOST;
    assign htif_pcr_req_data   = '0;
    assign htif_pcr_resp_ready = (state_q == ST_RD_RESP) || (state_q == ST_CLR_RESP);
    assign msg_valid           = (state_q == ST_PUSH);

    assign htif_reset = htif_reset_q;
    assign msg_data   = msg_data_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign exit_code  = exit_code_q;

    assign req_fire  = htif_pcr_req_valid && htif_pcr_req_ready;
    assign resp_fire = htif_pcr_resp_ready && htif_pcr_resp_valid;
    assign msg_fire  = msg_valid && msg_ready;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        htif_reset_d = htif_reset_q;
        msg_data_d   = msg_data_q;
        done_d       = done_q;
        pass_d       = pass_q;
        exit_code_d  = exit_code_q;

        case (state_q)
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    htif_reset_d = 1'b0;
                    cnt_d        = POLL_LOAD;
                    state_d      = ST_WAIT;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RD_REQ;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_RD_REQ: begin
                if (req_fire) state_d = ST_RD_RESP;
            end
            ST_RD_RESP: begin
                if (resp_fire) begin
                    if (htif_pcr_resp_data == '0) begin
                        cnt_d   = POLL_LOAD;
                        state_d = ST_WAIT;
                    end else begin
                        msg_data_d = htif_pcr_resp_data;
                        state_d    = ST_CLR_REQ;
                    end
                end
            end
            ST_CLR_REQ: begin
                if (req_fire) state_d = ST_CLR_RESP;
            end
            ST_CLR_RESP: begin
                if (resp_fire) state_d = ST_PUSH;
            end
            ST_PUSH: begin
                if (msg_fire) begin
                    if (is_exit_msg(msg_data_q)) begin
                        done_d      = 1'b1;
                        pass_d      = (msg_data_q == HTIF_PCR_WIDTH'(1));
                        exit_code_d = msg_data_q[HTIF_PCR_WIDTH-1:1];
                        state_d     = ST_HALT;
                    end else begin
                        cnt_d   = POLL_LOAD;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q      <= ST_HOLD;
            cnt_q        <= '0;
            htif_reset_q <= 1'b1;
            msg_data_q   <= '0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            exit_code_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            htif_reset_q <= htif_reset_d;
            msg_data_q   <= msg_data_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            exit_code_q  <= exit_code_d;
        end
    end

endmodule
